snoop_responder_msi: RTL

//  Bus-side (snoop) half of the MSI controller: consumes coherence messages placed on the bus by

---
 rtl/msi_pkg.sv | 25 ++
 rtl/snoop_state_table.sv | 41 ++++
 rtl/snoop_responder_msi.sv | 121 ++++++++++++
 3 files changed

// File: rtl/msi_pkg.sv
// msi_pkg: MSI line-state codes, bus message codes, snoop FSM states and the snoop transition function.
package msi_pkg;
  localparam logic [1:0] ST_I    = 2'b00;
  localparam logic [1:0] ST_S    = 2'b01;
  localparam logic [1:0] ST_M    = 2'b10;
  localparam logic [1:0] ST_NONE = 2'b11;
  localparam logic [1:0] MSG_NONE = 2'b00;
  localparam logic [1:0] MSG_RD   = 2'b01;
  localparam logic [1:0] MSG_WR   = 2'b10;
  localparam logic [1:0] MSG_INV  = 2'b11;
  typedef enum logic [1:0] {FSM_IDLE, FSM_LOOKUP, FSM_WB, FSM_DONE} fsm_t;
  // Returns {write_back, next_state} for a hit line; non-hit callers ignore it.
  function automatic logic [2:0] msi_xfer(input logic [1:0] st, input logic [1:0] msg);
    logic       wb;
    logic [1:0] nx;
    nx = st;
    wb = 1'b0;
    if (st == ST_S && (msg == MSG_WR || msg == MSG_INV)) nx = ST_I;
    if (st == ST_M && msg != MSG_NONE) begin
      nx = (msg == MSG_RD) ? ST_S : ST_I;
      wb = (msg != MSG_INV);
    end
    return {wb, nx};
  endfunction
endpackage

// File: rtl/snoop_state_table.sv
// snoop_state_table: per-line tag and MSI state registers, one read port, snoop write over local write.
module snoop_state_table
  import msi_pkg::*;
#(
  parameter int NUM_LINES = 4,
  parameter int TAG_W     = 6,
  localparam int IDX_W    = $clog2(NUM_LINES)
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [IDX_W-1:0] i_rd_idx,
  output logic [TAG_W-1:0] o_rd_tag,
  output logic [1:0]       o_rd_st,
  input  logic             i_su_we,
  input  logic [IDX_W-1:0] i_su_idx,
  input  logic [1:0]       i_su_st,
  input  logic             i_lw_we,
  input  logic [IDX_W-1:0] i_lw_idx,
  input  logic [TAG_W-1:0] i_lw_tag,
  input  logic [1:0]       i_lw_st
);
  logic [TAG_W-1:0] r_tag [NUM_LINES];
  logic [1:0]       r_st  [NUM_LINES];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_LINES; i++) begin
        r_tag[i] <= '0;
        r_st[i]  <= ST_I;
      end
    end else if (i_su_we) begin
      r_st[i_su_idx] <= i_su_st;
    end else if (i_lw_we) begin
      r_tag[i_lw_idx] <= i_lw_tag;
      r_st[i_lw_idx]  <= i_lw_st;
    end
  end

  assign o_rd_tag = r_tag[i_rd_idx];
  assign o_rd_st  = r_st[i_rd_idx];
endmodule

// File: rtl/snoop_responder_msi.sv
// snoop_responder_msi: bus-side MSI snoop FSM owning the line-state table.
// Define SNOOP_STATS_EN to add saturating stat_inv/stat_wb counters.
module snoop_responder_msi
  import msi_pkg::*;
#(
  parameter int NUM_LINES = 4,
  parameter int ADDR_W    = 8
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              run,
  input  logic              bus_valid,
  input  logic [1:0]        bus_msg,
  input  logic [ADDR_W-1:0] bus_addr,
  output logic              bus_ready,
  input  logic              local_we,
  input  logic [ADDR_W-1:0] local_addr,
  input  logic [1:0]        local_estado,
  output logic              wb_req,
  output logic [ADDR_W-1:0] wb_addr,
  input  logic              wb_ack,
  output logic              snoop_done,
  output logic              snoop_hit,
  output logic              abort_mem,
  output logic [1:0]        estado_novo
`ifdef SNOOP_STATS_EN
  ,
  output logic [15:0]       stat_inv,
  output logic [15:0]       stat_wb
`endif
);
  localparam int IDX_W = $clog2(NUM_LINES);
  localparam int TAG_W = ADDR_W - IDX_W;

  fsm_t              r_fsm, w_next;
  logic [1:0]        r_msg, r_new;
  logic [ADDR_W-1:0] r_addr;
  logic              r_hit, r_wb;
  logic              w_idle, w_accept, w_hit, w_wb;
  logic [TAG_W-1:0]  w_rd_tag;
  logic [1:0]        w_rd_st, w_new;
  logic [2:0]        w_xfer;

  assign w_idle   = r_fsm == FSM_IDLE;
  assign w_accept = w_idle & run & ~local_we & bus_valid;
  assign w_hit    = (w_rd_tag == r_addr[ADDR_W-1:IDX_W]) && w_rd_st != ST_I;
  assign w_xfer   = msi_xfer(w_rd_st, r_msg);
  assign w_wb     = w_hit & w_xfer[2];
  assign w_new    = w_hit ? w_xfer[1:0] : w_rd_st;

  snoop_state_table #(.NUM_LINES(NUM_LINES), .TAG_W(TAG_W)) u_table (
    .clock    (clock),
    .reset_n  (reset_n),
    .i_rd_idx (r_addr[IDX_W-1:0]),
    .o_rd_tag (w_rd_tag),
    .o_rd_st  (w_rd_st),
    .i_su_we  (snoop_done & r_hit),
    .i_su_idx (r_addr[IDX_W-1:0]),
    .i_su_st  (r_new),
    .i_lw_we  (w_idle & local_we & (local_estado != ST_NONE)),
    .i_lw_idx (local_addr[IDX_W-1:0]),
    .i_lw_tag (local_addr[ADDR_W-1:IDX_W]),
    .i_lw_st  (local_estado)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) r_fsm <= FSM_IDLE;
    else r_fsm <= w_next;
  end

  // A "none" bus message is accepted but never leaves IDLE.
  always_comb begin
    w_next = r_fsm;
    case (r_fsm)
      FSM_IDLE:   w_next = (w_accept && bus_msg != MSG_NONE) ? FSM_LOOKUP : FSM_IDLE;
      FSM_LOOKUP: w_next = w_wb ? FSM_WB : FSM_DONE;
      FSM_WB:     w_next = wb_ack ? FSM_DONE : FSM_WB;
      default:    w_next = FSM_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_msg  <= MSG_NONE;
      r_addr <= '0;
      r_hit  <= 1'b0;
      r_wb   <= 1'b0;
      r_new  <= ST_NONE;
    end else begin
      if (w_accept) begin
        r_msg  <= bus_msg;
        r_addr <= bus_addr;
      end
      if (r_fsm == FSM_LOOKUP) begin
        r_hit <= w_hit;
        r_wb  <= w_wb;
        r_new <= w_new;
      end
    end
  end

  assign bus_ready   = w_idle & run & ~local_we;
  assign wb_req      = r_fsm == FSM_WB;
  assign wb_addr     = wb_req ? r_addr : '0;
  assign snoop_done  = r_fsm == FSM_DONE;
  assign snoop_hit   = snoop_done & r_hit;
  assign abort_mem   = snoop_done & r_wb;
  assign estado_novo = snoop_done ? r_new : ST_NONE;

`ifdef SNOOP_STATS_EN
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      stat_inv <= '0;
      stat_wb  <= '0;
    end else if (snoop_done) begin
      if (r_hit && r_new == ST_I && stat_inv != 16'hFFFF) stat_inv <= stat_inv + 16'd1;
      if (r_wb && stat_wb != 16'hFFFF) stat_wb <= stat_wb + 16'd1;
    end
  end
`endif
endmodule
